// File: rtl/eio_pkg.sv
// Shared definitions for the EIO register responder: register map, FSM states, request payload.
package eio_pkg;

   localparam int unsigned WINDOW_BYTES = 64;
   localparam int unsigned OFF_W        = 6;
   localparam int unsigned NUM_SCR      = 8;

   localparam logic [OFF_W-1:0] OFF_SCR0     = 6'h00;
   localparam logic [OFF_W-1:0] OFF_SCR_END  = 6'h20;
   localparam logic [OFF_W-1:0] OFF_CYCLE_LO = 6'h20;
   localparam logic [OFF_W-1:0] OFF_CYCLE_HI = 6'h24;
   localparam logic [OFF_W-1:0] OFF_STATUS   = 6'h28;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_e;

   typedef enum logic [2:0] {
      REG_SCR,
      REG_CYCLE_LO,
      REG_CYCLE_HI,
      REG_STATUS,
      REG_NONE
   } reg_sel_e;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wr_data;
   } req_t;

endpackage

// File: rtl/eio_decode.sv
// Combinational address decode and fault classification for one EIO access.
// CYCLE_LO/CYCLE_HI are mapped only when EIO_TIMER_EN is defined.
module eio_decode
   import eio_pkg::*;
#(
   parameter logic [31:0] EIO_BASE = 32'h8000_0000
) (
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   output logic        fault_c,
   output reg_sel_e    sel_c,
   output logic [2:0]  scr_idx_c
);

   logic [31:0]      offs;
   logic [OFF_W-1:0] off;

   always_comb begin
      offs      = addr - EIO_BASE;
      off       = offs[OFF_W-1:0];
      sel_c     = REG_NONE;
      scr_idx_c = off[4:2];

      if (off < OFF_SCR_END) begin
         sel_c = REG_SCR;
      end else begin
         case (off)
            OFF_STATUS:   sel_c = REG_STATUS;
`ifdef EIO_TIMER_EN
            OFF_CYCLE_LO: sel_c = REG_CYCLE_LO;
            OFF_CYCLE_HI: sel_c = REG_CYCLE_HI;
`endif
            default:      sel_c = REG_NONE;
         endcase
      end

      // Only the scratch registers are writable.
      fault_c = (offs >= 32'(WINDOW_BYTES))
             || (addr[1:0] != 2'b00)
             || (rd == wr)
             || (sel_c == REG_NONE)
             || (wr && (sel_c != REG_SCR));
   end

endmodule

// File: rtl/eio_responder.sv
// EIO register responder: IDLE/WAIT/ACK handshake over scratch, status and optional cycle-counter registers.
// Optional feature macro: EIO_TIMER_EN (adds CYCLE_LO/CYCLE_HI over a 64-bit free-running counter).
module eio_responder
   import eio_pkg::*;
#(
   parameter logic [31:0] EIO_BASE = 32'h8000_0000,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        eio_req,
   input  logic        eio_rd,
   input  logic        eio_wr,
   input  logic [31:0] eio_addr,
   input  logic [31:0] eio_wr_data,
   output logic        eio_ack,
   output logic        eio_ack_fault,
   output logic [31:0] eio_ack_data
);

   localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

   state_e      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;
   logic        capture, enter_ack;
   req_t        live, cap_q, cur;
   logic        dec_fault;
   reg_sel_e    dec_sel;
   logic [2:0]  dec_idx;
   logic [31:0] scr [NUM_SCR];
   logic [15:0] fault_cnt;
   logic [31:0] rd_data;

   assign live = '{rd: eio_rd, wr: eio_wr, addr: eio_addr, wr_data: eio_wr_data};

   // In IDLE the accepting cycle decodes the live request (needed when WAIT_CYC=0).
   assign cur = (state == S_IDLE) ? live : cap_q;

   eio_decode #(.EIO_BASE(EIO_BASE)) u_decode (
      .rd        (cur.rd),
      .wr        (cur.wr),
      .addr      (cur.addr),
      .fault_c   (dec_fault),
      .sel_c     (dec_sel),
      .scr_idx_c (dec_idx)
   );

`ifdef EIO_TIMER_EN
   logic [63:0] cycle_cnt;
   logic [31:0] hi_snap;

   // Free-running counter; HI half is snapshotted when CYCLE_LO is read.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         cycle_cnt <= '0;
         hi_snap   <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (enter_ack && !dec_fault && (dec_sel == REG_CYCLE_LO)) begin
            hi_snap <= cycle_cnt[63:32];
         end
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      case (dec_sel)
         REG_SCR:      rd_data = scr[dec_idx];
         REG_STATUS:   rd_data = {16'h0000, fault_cnt};
`ifdef EIO_TIMER_EN
         REG_CYCLE_LO: rd_data = cycle_cnt[31:0];
         REG_CYCLE_HI: rd_data = hi_snap;
`endif
         default:      rd_data = '0;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      capture      = 1'b0;
      enter_ack    = 1'b0;
      case (state)
         S_IDLE: begin
            if (eio_req) begin
               capture = 1'b1;
               if (WAIT_CYC == 0) begin
                  state_nxt = S_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = S_ACK;
               enter_ack = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         cap_q         <= '0;
         eio_ack       <= 1'b0;
         eio_ack_fault <= 1'b0;
         eio_ack_data  <= '0;
         fault_cnt     <= '0;
         for (int i = 0; i < int'(NUM_SCR); i++) begin
            scr[i] <= '0;
         end
      end else begin
         state         <= state_nxt;
         wait_cnt      <= wait_cnt_nxt;
         eio_ack       <= enter_ack;
         eio_ack_fault <= enter_ack && dec_fault;
         eio_ack_data  <= (enter_ack && !dec_fault && cur.rd) ? rd_data : 32'h0;
         if (capture) begin
            cap_q <= live;
         end
         // Side effects commit at the edge that ends the ACK cycle.
         if (state == S_ACK) begin
            if (eio_ack_fault) begin
               if (fault_cnt != 16'hFFFF) begin
                  fault_cnt <= fault_cnt + 16'd1;
               end
            end else if (cap_q.wr) begin
               scr[dec_idx] <= cap_q.wr_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_eio_responder.sv
// Self-checking bench for eio_responder: directed scenarios plus randomized accesses against a register-map model.
module tb_eio_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          WCYC = 2;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        req, rd, wr;
   logic [31:0] addr, wdata;
   logic        ack, ack_fault;
   logic [31:0] ack_data;
   logic        req0, rd0, wr0;
   logic [31:0] addr0, wdata0;
   logic        ack0, ack_fault0;
   logic [31:0] ack_data0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_scr [8];
   int unsigned m_fcnt;

   always #5 clk_in = ~clk_in;

   eio_responder #(.EIO_BASE(BASE), .WAIT_CYC(WCYC)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .eio_req(req), .eio_rd(rd), .eio_wr(wr),
      .eio_addr(addr), .eio_wr_data(wdata), .eio_ack(ack), .eio_ack_fault(ack_fault),
      .eio_ack_data(ack_data)
   );

   eio_responder #(.EIO_BASE(BASE), .WAIT_CYC(0)) dut0 (
      .clk_in(clk_in), .reset_in(reset_in), .eio_req(req0), .eio_rd(rd0), .eio_wr(wr0),
      .eio_addr(addr0), .eio_wr_data(wdata0), .eio_ack(ack0), .eio_ack_fault(ack_fault0),
      .eio_ack_data(ack_data0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Register-map reference: decides fault/data from the address rules and updates model state.
   function automatic void model(input logic r, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, output logic f, output logic [31:0] q);
      logic [31:0] off;
      off = a - BASE;
      f   = 1'b1;
      q   = 32'h0;
      if (off < 32'd64 && a[1:0] == 2'b00 && r != w) begin
         if (off < 32'd32) begin
            f = 1'b0;
            if (r) q = m_scr[off[4:2]];
            else   m_scr[off[4:2]] = d;
         end else if (off == 32'h28 && r) begin
            f = 1'b0;
            q = {16'h0, 16'(m_fcnt)};
         end
      end
      if (f && m_fcnt < 32'hFFFF) m_fcnt++;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_scr[i] = 32'h0;
      m_fcnt = 0;
   endfunction

   // One handshake on dut; optionally scrambles the attributes after acceptance.
   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, output logic f, output logic [31:0] q, output int lat);
      @(negedge clk_in);
      req = 1'b1; rd = r; wr = w; addr = a; wdata = d;
      lat = 0; f = 1'bx; q = 'x;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk_in); #1;
         if (ack) begin
            lat = k; f = ack_fault; q = ack_data;
            break;
         end
         if (k == 1 && scramble) begin
            addr = $urandom; wdata = $urandom; rd = 1'($urandom); wr = 1'($urandom);
         end
      end
      req = 1'b0;
      if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
      @(posedge clk_in);
   endtask

   task automatic run_txn(input string tag, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
      logic        ef, f;
      logic [31:0] ed, q;
      int          lat;
      model(r, w, a, d, ef, ed);
      access(r, w, a, d, scramble, f, q, lat);
      chk({tag, "_fault"}, 32'(f), 32'(ef));
      chk({tag, "_data"}, q, ed);
      chk({tag, "_lat"}, 32'(lat), 32'(WCYC + 1));
   endtask

   initial begin
      logic        f;
      logic [31:0] q, lo, hi, a;
      int          lat, kind, op;
      logic        r, w;

      reset_in = 1'b1;
      req = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
      req0 = 0; rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_fault", 32'(ack_fault), 32'd0);
      chk("rst_data", ack_data, 32'd0);
      chk("rst_ack0", 32'(ack0), 32'd0);
      @(negedge clk_in);
      reset_in = 1'b0;

      // Basic write/read of SCR1.
      run_txn("wr_scr1", 1'b0, 1'b1, BASE + 32'h4, 32'h1234_5678, 1'b0);
      run_txn("rd_scr1", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 1'b1);
      chk("rd_scr1_model", m_scr[1], 32'h1234_5678);

      // Three fault classes, then STATUS.
      run_txn("oow", 1'b1, 1'b0, BASE + 32'h40, 32'h0, 1'b0);
      run_txn("misalign", 1'b0, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 1'b0);
      run_txn("rdwr", 1'b1, 1'b1, BASE + 32'h8, 32'h5555_AAAA, 1'b0);
      access(1'b1, 1'b0, BASE + 32'h28, 32'h0, 1'b0, f, q, lat);
      chk("status3", q, 32'h0000_0003);
      chk("status3_fault", 32'(f), 32'd0);

`ifdef EIO_TIMER_EN
      @(negedge clk_in);
      force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFE;
      @(posedge clk_in); #1;
      release dut.cycle_cnt;
      access(1'b1, 1'b0, BASE + 32'h20, 32'h0, 1'b0, f, lo, lat);
      chk("cyc_lo_fault", 32'(f), 32'd0);
      chk("cyc_lo_range", 32'(lo < 32'd64 || lo >= 32'hFFFF_FFC0), 32'd1);
      repeat (5) @(posedge clk_in);
      access(1'b1, 1'b0, BASE + 32'h24, 32'h0, 1'b0, f, hi, lat);
      chk("cyc_hi_fault", 32'(f), 32'd0);
      chk("cyc_hi_snap", hi, (lo >= 32'hFFFF_FFC0) ? 32'd1 : 32'd2);
      run_txn("wr_cyc_lo", 1'b0, 1'b1, BASE + 32'h20, 32'h1, 1'b0);
`else
      run_txn("rd_cyc_lo", 1'b1, 1'b0, BASE + 32'h20, 32'h0, 1'b0);
      run_txn("rd_cyc_hi", 1'b1, 1'b0, BASE + 32'h24, 32'h0, 1'b0);
`endif

      // Randomized accesses against the model.
      for (int i = 0; i < 60; i++) begin
         kind = int'($urandom_range(0, 9));
         op   = int'($urandom_range(0, 7));
         if (kind == 0)      a = BASE + 32'h40 + ($urandom_range(0, 15) << 2);
         else if (kind == 1) a = BASE + 32'h80000000 + ($urandom_range(0, 15) << 2);
         else if (kind == 2) a = BASE + ($urandom_range(0, 15) << 2) + 32'($urandom_range(1, 3));
         else                a = BASE + ($urandom_range(0, 15) << 2);
`ifdef EIO_TIMER_EN
         if (a == BASE + 32'h20 || a == BASE + 32'h24) a = BASE + 32'h28;
`endif
         r = (op == 0) || (op >= 2 && op <= 4);
         w = (op == 0) || (op >= 5);
         if (op == 1) begin r = 1'b0; w = 1'b0; end
         run_txn($sformatf("rnd%0d", i), r, w, a, $urandom, 1'b1);
      end
      for (int i = 0; i < 8; i++) run_txn($sformatf("sweep%0d", i), 1'b1, 1'b0, BASE + 32'(i * 4), 32'h0, 1'b0);
      run_txn("sweep_status", 1'b1, 1'b0, BASE + 32'h28, 32'h0, 1'b0);

      // Reset in WAIT abandons a write to SCR0.
      @(negedge clk_in);
      req = 1'b1; rd = 1'b0; wr = 1'b1; addr = BASE; wdata = 32'hDEAD_BEEF;
      @(posedge clk_in); #1;
      chk("abort_noack1", 32'(ack), 32'd0);
      @(negedge clk_in);
      reset_in = 1'b1; req = 1'b0;
      @(posedge clk_in); #1;
      chk("abort_noack2", 32'(ack), 32'd0);
      @(negedge clk_in);
      reset_in = 1'b0;
      model_reset();
      repeat (4) @(posedge clk_in);
      #1;
      chk("abort_noack3", 32'(ack), 32'd0);
      run_txn("abort_scr0", 1'b1, 1'b0, BASE, 32'h0, 1'b0);
      run_txn("abort_status", 1'b1, 1'b0, BASE + 32'h28, 32'h0, 1'b0);

      // Zero-wait instance: req held across ACK yields a second accept two cycles later.
      @(negedge clk_in);
      req0 = 1'b1; rd0 = 1'b0; wr0 = 1'b1; addr0 = BASE + 32'h4; wdata0 = 32'hCAFE_0001;
      @(posedge clk_in); #1;
      chk("b2b_ack1", 32'(ack0), 32'd1);
      chk("b2b_fault1", 32'(ack_fault0), 32'd0);
      rd0 = 1'b1; wr0 = 1'b0;
      @(posedge clk_in); #1;
      chk("b2b_gap", 32'(ack0), 32'd0);
      @(posedge clk_in); #1;
      chk("b2b_ack2", 32'(ack0), 32'd1);
      chk("b2b_data2", ack_data0, 32'hCAFE_0001);
      req0 = 1'b0;
      @(posedge clk_in); #1;
      chk("b2b_after", 32'(ack0), 32'd0);
      repeat (3) @(posedge clk_in);
      #1;
      chk("b2b_idle", 32'(ack0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
